// File: rtl/ticket_dispatch_scheduler_pkg.sv
// rtl/ticket_dispatch_scheduler_pkg.sv - shared constants, service codes and queue entry for the ticket scheduler
package bank_pkg;

    localparam int NUM_OFFICERS = 4;
    localparam int QUEUE_DEPTH  = 8;
    localparam int TICKET_W     = 7;
    localparam int MAX_TICKET   = 99;
    localparam int SERVICE_W    = 2;

    typedef enum logic [SERVICE_W-1:0] {
        SVC_DEPOSIT  = 2'd0,
        SVC_WITHDRAW = 2'd1,
        SVC_LOAN     = 2'd2,
        SVC_ENQUIRY  = 2'd3
    } service_t;

    typedef struct packed {
        logic [TICKET_W-1:0] ticket;
        service_t            service;
    } queue_entry_t;

    // Ticket 0 is reserved for "nothing called yet", so the sequence wraps to 1.
    function automatic logic [TICKET_W-1:0] next_ticket(input logic [TICKET_W-1:0] t,
                                                        input int max_ticket);
        return (int'(t) == max_ticket) ? TICKET_W'(1) : t + 1'b1;
    endfunction

endpackage

// File: rtl/ticket_dispatch_scheduler_if.sv
// rtl/ticket_dispatch_scheduler_if.sv - kiosk, officer button and display signals of the ticket scheduler
interface ticket_dispatch_scheduler_if #(
    parameter int NUM_OFFICERS = 4,
    parameter int QUEUE_DEPTH  = 8,
    parameter int TICKET_W     = 7
);
    import bank_pkg::*;

    localparam int COUNT_W = $clog2(QUEUE_DEPTH + 1);

    logic                    take_ticket;
    logic [SERVICE_W-1:0]    service_req;
    logic [NUM_OFFICERS-1:0] officer_button;

    logic                    ticket_issued;
    logic [TICKET_W-1:0]     issued_ticket;
    logic                    ticket_rejected;
    logic                    call_valid;
    logic [TICKET_W-1:0]     call_ticket;
    logic [2:0]              call_officer;
    logic [SERVICE_W-1:0]    call_service;
    logic [COUNT_W-1:0]      waiting_count;
    logic                    queue_full;
    logic                    queue_empty;

    modport master (
        output take_ticket, service_req, officer_button,
        input  ticket_issued, issued_ticket, ticket_rejected, call_valid, call_ticket,
               call_officer, call_service, waiting_count, queue_full, queue_empty
    );

    modport slave (
        input  take_ticket, service_req, officer_button,
        output ticket_issued, issued_ticket, ticket_rejected, call_valid, call_ticket,
               call_officer, call_service, waiting_count, queue_full, queue_empty
    );

endinterface

// File: rtl/ticket_dispatch_scheduler_rr_arbiter.sv
// rtl/ticket_dispatch_scheduler_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(pointer) + k) % N;
            if (!grant_valid && request[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ticket_dispatch_scheduler.sv
// rtl/ticket_dispatch_scheduler.sv - ticket FIFO with round-robin dispatch of the oldest ticket to officers
module ticket_dispatch_scheduler #(
    parameter int NUM_OFFICERS = 4,
    parameter int QUEUE_DEPTH  = 8,
    parameter int TICKET_W     = 7,
    parameter int MAX_TICKET   = 99
) (
    input  logic                          clk,
    input  logic                          reset,
    ticket_dispatch_scheduler_if.slave    bus
);
    import bank_pkg::*;

    localparam int IDX_W   = (NUM_OFFICERS > 1) ? $clog2(NUM_OFFICERS) : 1;
    localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int COUNT_W = $clog2(QUEUE_DEPTH + 1);

    queue_entry_t            mem [QUEUE_DEPTH];
    queue_entry_t            head;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [COUNT_W-1:0]      count, count_n;
    logic [TICKET_W-1:0]     ticket_ctr;

    logic [NUM_OFFICERS-1:0] btn_q, rise, pending, grant;
    logic [IDX_W-1:0]        rr_ptr, grant_idx;
    logic                    grant_valid;
    logic                    push, pop;

    assign rise = bus.officer_button & ~btn_q;
    // Full check uses the registered count, so a pop in the same cycle never frees a slot early.
    assign push = bus.take_ticket && (count != COUNT_W'(QUEUE_DEPTH));
    assign pop  = grant_valid && (count != '0);
    assign head = mem[rd_ptr];

    rr_arbiter #(.N(NUM_OFFICERS), .IDX_W(IDX_W)) u_arb (
        .request     (pending),
        .pointer     (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ticket: ticket_ctr, service: service_t'(bus.service_req)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ticket_ctr <= TICKET_W'(1);
            btn_q      <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
        end else begin
            btn_q <= bus.officer_button;
            // A press while already pending is dropped; the winner's bit clears on its grant.
            pending <= (pending & ~(pop ? grant : '0)) | (rise & ~pending);
            count   <= count_n;
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                ticket_ctr <= next_ticket(ticket_ctr, MAX_TICKET);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rr_ptr <= (int'(grant_idx) == NUM_OFFICERS - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ticket_issued   <= 1'b0;
            bus.issued_ticket   <= '0;
            bus.ticket_rejected <= 1'b0;
            bus.call_valid      <= 1'b0;
            bus.call_ticket     <= '0;
            bus.call_officer    <= '0;
            bus.call_service    <= '0;
            bus.queue_full      <= 1'b0;
            bus.queue_empty     <= 1'b1;
        end else begin
            bus.ticket_issued   <= push;
            bus.ticket_rejected <= bus.take_ticket && !push;
            bus.call_valid      <= pop;
            bus.queue_full      <= (count_n == COUNT_W'(QUEUE_DEPTH));
            bus.queue_empty     <= (count_n == '0);
            if (push) begin
                bus.issued_ticket <= ticket_ctr;
            end
            if (pop) begin
                bus.call_ticket  <= head.ticket;
                bus.call_service <= head.service;
                bus.call_officer <= 3'(int'(grant_idx) + 1);
            end
        end
    end

    assign bus.waiting_count = count;

endmodule

// File: tb/tb_ticket_dispatch_scheduler.sv
// tb/tb_ticket_dispatch_scheduler.sv - table-driven and sequenced checks of the ticket dispatch scheduler
module tb_ticket_dispatch_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ticket_dispatch_scheduler_if bus ();

    ticket_dispatch_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       take;
        logic [1:0] svc;
        logic [3:0] btn;
        logic       ti;
        logic [6:0] it;
        logic       tr;
        logic       cv;
        logic [6:0] ct;
        logic [2:0] co;
        logic [1:0] cs;
        logic [3:0] wc;
        logic       qf;
        logic       qe;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic [1:0] s, input logic [3:0] b);
        reset              = r;
        bus.take_ticket    = t;
        bus.service_req    = s;
        bus.officer_button = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        drive(0, 0, 0, 4'b0001);
        step();
        step();
        check("pop_one call_valid", bus.call_valid, 1);
        drive(0, 0, 0, 4'b0000);
        step();
    endtask

    int ncalls;
    int exp_t;

    initial begin
        for (int i = 0; i < 3; i++) tbl[i] = '{1,0,0,4'h0, 0,0,0,0,0,0,0,0,0,1};
        for (int i = 3; i < 8; i++) tbl[i] = '{0,0,0,4'h0, 0,0,0,0,0,0,0,0,0,1};
        tbl[8]  = '{0,1,0,4'h0, 1,1,0,0,0,0,0,1,0,0};
        tbl[9]  = '{0,1,1,4'h0, 1,2,0,0,0,0,0,2,0,0};
        tbl[10] = '{0,1,2,4'h0, 1,3,0,0,0,0,0,3,0,0};
        tbl[11] = '{0,0,0,4'h2, 0,3,0,0,0,0,0,3,0,0};
        tbl[12] = '{0,0,0,4'h2, 0,3,0,1,1,2,0,2,0,0};
        tbl[13] = '{0,0,0,4'h0, 0,3,0,0,1,2,0,2,0,0};
        tbl[14] = '{1,0,0,4'h0, 0,0,0,0,0,0,0,0,0,1};
        tbl[15] = '{0,1,3,4'h0, 1,1,0,0,0,0,0,1,0,0};
        tbl[16] = '{0,0,0,4'h5, 0,1,0,0,0,0,0,1,0,0};
        tbl[17] = '{0,0,0,4'h5, 0,1,0,1,1,1,3,0,0,1};
        tbl[18] = '{0,0,0,4'h0, 0,1,0,0,1,1,3,0,0,1};
        tbl[19] = '{0,0,0,4'h1, 0,1,0,0,1,1,3,0,0,1};
        tbl[20] = '{0,1,1,4'h1, 1,2,0,0,1,1,3,1,0,0};
        tbl[21] = '{0,0,0,4'h0, 0,2,0,1,2,3,1,0,0,1};
        tbl[22] = '{0,1,0,4'h0, 1,3,0,0,2,3,1,1,0,0};
        tbl[23] = '{0,0,0,4'h0, 0,3,0,1,3,1,0,0,0,1};
        tbl[24] = '{0,0,0,4'h0, 0,3,0,0,3,1,0,0,0,1};

        drive(1, 0, 0, 4'h0);
        #2;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].take, tbl[i].svc, tbl[i].btn);
            step();
            check($sformatf("v%0d ticket_issued", i),   bus.ticket_issued,   tbl[i].ti);
            check($sformatf("v%0d issued_ticket", i),   bus.issued_ticket,   tbl[i].it);
            check($sformatf("v%0d ticket_rejected", i), bus.ticket_rejected, tbl[i].tr);
            check($sformatf("v%0d call_valid", i),      bus.call_valid,      tbl[i].cv);
            check($sformatf("v%0d call_ticket", i),     bus.call_ticket,     tbl[i].ct);
            check($sformatf("v%0d call_officer", i),    bus.call_officer,    tbl[i].co);
            check($sformatf("v%0d call_service", i),    bus.call_service,    tbl[i].cs);
            check($sformatf("v%0d waiting_count", i),   bus.waiting_count,   tbl[i].wc);
            check($sformatf("v%0d queue_full", i),      bus.queue_full,      tbl[i].qf);
            check($sformatf("v%0d queue_empty", i),     bus.queue_empty,     tbl[i].qe);
        end

        // Queue full, rejection with concurrent pop, and ticket wrap.
        drive(1, 0, 0, 4'h0); step();
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 2'(i), 4'h0);
            step();
            check("fill issued_ticket", bus.issued_ticket, i);
        end
        check("fill queue_full", bus.queue_full, 1);
        drive(0, 1, 0, 4'h0); step();
        check("full rejected", bus.ticket_rejected, 1);
        check("full no issue", bus.ticket_issued, 0);
        check("full waiting", bus.waiting_count, 8);
        check("full issued holds", bus.issued_ticket, 8);
        drive(0, 0, 0, 4'b0010); step();
        check("full press no call", bus.call_valid, 0);
        drive(0, 1, 0, 4'b0010); step();
        check("pop+full call_valid", bus.call_valid, 1);
        check("pop+full call_ticket", bus.call_ticket, 1);
        check("pop+full call_officer", bus.call_officer, 2);
        check("pop+full rejected", bus.ticket_rejected, 1);
        check("pop+full waiting", bus.waiting_count, 7);
        drive(0, 1, 0, 4'h0); step();
        check("after pop issued", bus.issued_ticket, 9);
        check("after pop waiting", bus.waiting_count, 8);
        for (int t = 10; t <= 100; t++) begin
            pop_one();
            exp_t = (t > 99) ? 1 : t;
            drive(0, 1, 0, 4'h0); step();
            check($sformatf("wrap issued t%0d", t), bus.issued_ticket, exp_t);
        end

        // Empty queue: the request waits, then takes the first pushed ticket.
        drive(1, 0, 0, 4'h0); step();
        drive(0, 0, 0, 4'b1000); step();
        drive(0, 0, 0, 4'h0);
        ncalls = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.call_valid) ncalls++;
        end
        check("empty no calls", ncalls, 0);
        drive(0, 1, 1, 4'h0); step();
        check("empty push issued", bus.ticket_issued, 1);
        check("empty push no bypass", bus.call_valid, 0);
        drive(0, 0, 0, 4'h0); step();
        check("empty late call_valid", bus.call_valid, 1);
        check("empty late call_officer", bus.call_officer, 4);
        check("empty late call_ticket", bus.call_ticket, 1);
        check("empty late call_service", bus.call_service, 1);

        // Simultaneous push and pop, then reset with a pending officer.
        drive(0, 1, 0, 4'h0); step();
        drive(0, 1, 0, 4'h0); step();
        check("pp setup waiting", bus.waiting_count, 2);
        drive(0, 0, 0, 4'b0010); step();
        check("pp press no call", bus.call_valid, 0);
        drive(0, 1, 2, 4'b0010); step();
        check("pp issued", bus.ticket_issued, 1);
        check("pp issued_ticket", bus.issued_ticket, 4);
        check("pp call_valid", bus.call_valid, 1);
        check("pp call_ticket", bus.call_ticket, 2);
        check("pp waiting", bus.waiting_count, 2);
        drive(0, 0, 0, 4'b0100); step();
        check("pre-reset no call", bus.call_valid, 0);
        drive(1, 0, 0, 4'h0); step();
        check("reset call_valid", bus.call_valid, 0);
        check("reset waiting", bus.waiting_count, 0);
        check("reset empty", bus.queue_empty, 1);
        check("reset officer", bus.call_officer, 0);
        drive(0, 1, 3, 4'h0); step();
        check("post-reset issued", bus.issued_ticket, 1);
        drive(0, 0, 0, 4'h0);
        ncalls = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.call_valid) ncalls++;
        end
        check("post-reset no stale call", ncalls, 0);
        drive(0, 0, 0, 4'b0100); step();
        step();
        check("fresh press call_valid", bus.call_valid, 1);
        check("fresh press officer", bus.call_officer, 3);
        check("fresh press ticket", bus.call_ticket, 1);
        check("fresh press service", bus.call_service, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ticket_dispatch_scheduler.md
Name: ticket_dispatch_scheduler

Overview:
Scheduler between the customer ticket kiosk and the officer counters of the bank ticket machine.
- Issues sequential ticket numbers and queues them in a FIFO with their service type.
- When officers press their counter buttons, round-robin arbitration decides which officer is served next; the oldest waiting ticket goes to that officer.
- Registered outputs feed the existing 7-segment display drivers: ticket, officer, service, waiting count.

Parameters:
NUM_OFFICERS, 4, number of officer counters/buttons
QUEUE_DEPTH, 8, maximum waiting tickets (power of two)
TICKET_W, 7, ticket number width
MAX_TICKET, 99, last ticket number before wrapping to 1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
take_ticket  in  1  kiosk request, one cycle per customer
service_req  in  2  service type accompanying take_ticket
officer_button  in  NUM_OFFICERS  debounced level buttons, bit i = officer i+1
ticket_issued  out  1  one-cycle pulse: ticket accepted
issued_ticket  out  TICKET_W  number of the last accepted ticket
ticket_rejected  out  1  one-cycle pulse: take_ticket dropped, queue full
call_valid  out  1  one-cycle pulse: new call registered
call_ticket  out  TICKET_W  ticket being called, held until next call
call_officer  out  3  1-based officer number called (0 = none yet)
call_service  out  2  service type of the called ticket
waiting_count  out  clog2(QUEUE_DEPTH+1)  tickets in queue
queue_full  out  1  waiting_count == QUEUE_DEPTH
queue_empty  out  1  waiting_count == 0

Behaviour:
Reset (synchronous, dominates all other inputs):
- All outputs are 0, except queue_empty = 1.
- FIFO emptied; pending requests cleared; button history cleared.
- Ticket counter = 1; arbitration pointer = officer index 0.

Ticket issue:
- take_ticket=1 at an edge with queue not full: push {counter, service_req}; issued_ticket <= counter; ticket_issued pulses.
- Counter then increments; at MAX_TICKET it wraps to 1. Ticket 0 is never issued.
- take_ticket while full: push refused, even if a pop occurs in the same cycle. ticket_rejected pulses; counter unchanged; issued_ticket holds.

Officer requests:
- Rising edge detection per bit against a registered copy of officer_button.
- A rising edge sets that officer's pending bit. Pending stays set until that officer is granted.
- A further press while pending is ignored; holding the button does not re-request.

Arbitration and dispatch:
- Each cycle, if pending != 0 and the queue is not empty, grant exactly one officer.
- The winner is the first pending officer at or after the pointer, wrapping modulo NUM_OFFICERS.
- On a grant, at the next edge:
  - pop the FIFO head;
  - call_ticket and call_service <= head fields; call_officer <= winner index + 1;
  - call_valid pulses;
  - the winner's pending bit clears;
  - pointer <= winner index + 1, wrapping.
- No grant leaves the pointer unchanged.

Timing and boundary cases:
- Latency: button sampled high (previously low) at edge k → pending after k → call outputs valid after edge k+1, if a ticket was queued before edge k.
- No FIFO bypass: a ticket pushed at edge t can be popped at edge t+1 at the earliest.
- Empty queue with pending officers: no call; requests wait.
- waiting_count: +1 on push only, −1 on pop only, unchanged when both occur in the same cycle.
- Reset during operation drops all queued tickets and pending calls in that cycle.

Decomposition:
Package bank_pkg holds:
- NUM_OFFICERS, MAX_TICKET, SERVICE_W = 2;
- service encodings: SVC_DEPOSIT = 0, SVC_WITHDRAW = 1, SVC_LOAN = 2, SVC_ENQUIRY = 3;
- the queue entry struct {ticket, service}.

One sub-module: rr_arbiter.
- Inputs: request vector, pointer.
- Outputs: one-hot grant, grant index, grant_valid.
- Purely combinational; the pointer register stays in the parent.
- The FIFO stays inline (pointers plus count).

Test Plan:
1. Reset held 3 cycles → all outputs 0, queue_empty=1, waiting_count=0. Release with no stimulus for 5 cycles → outputs unchanged, no pulses.
2. Three take_ticket pulses with service 0,1,2 → issued_ticket 1,2,3, waiting_count=3. Press officer 2 → one call_valid with call_ticket=1, call_officer=2, call_service=0, waiting_count=2.
3. Round robin, starting with 1 ticket waiting and pointer at 0:
   - Press officers 1 and 3 in the same cycle → officer 1 gets the ticket; officer 3 stays pending.
   - Press officer 1 again, then push one ticket → officer 3 is called before officer 1.
4. Queue full and wrap:
   - Push 8 tickets → queue_full=1. A 9th take_ticket → ticket_rejected pulse; waiting_count stays 8; next accepted ticket after a pop is 9.
   - Continue through ticket 99 → the next ticket issued is 1.
5. Empty queue: press officer 4 → no call_valid for 10 cycles. Push a ticket at edge t → call_valid after edge t+1 with call_officer=4.
6. Simultaneous push and pop at waiting_count=2 → waiting_count stays 2, one ticket_issued and one call_valid pulse. Reset asserted while officers are pending → after release, pending is empty and new tickets are not called until a fresh press.
